// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped down-counter timer with one-shot/auto-reload modes and masked IRQ
module tc_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        auto_reload;
    logic        unused_addr;

    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) state <= S_LOAD;
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // A count of 0 or 1 both terminate, so the counter never wraps.
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= S_INT;
                    end
                end
                S_INT: begin
                    if (auto_reload) irq_flag <= 1'b0;
                    else             ctrl[0]  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Bus writes come last so they override FSM updates to ctrl and the flag.
            if (WE) begin
                case (Addr[3:2])
                    2'd0: begin
                        ctrl     <= Din[3:0];
                        irq_flag <= 1'b0;
                    end
                    2'd1:    preset <= Din;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'd0:    Dout = {28'd0, ctrl};
            2'd1:    Dout = preset;
            2'd2:    Dout = count;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl[3] & irq_flag;

endmodule

// File: tb/tb_tc_timer.sv
// tb/tb_tc_timer.sv - self-checking bench for tc_timer
module tb_tc_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_cmp  = 0;
    int n_fail = 0;

    tc_timer dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  a;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'd0, a, 2'b00};
        #1;
        d = Dout;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a, 2'b00};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic wait_count(input logic [31:0] v, input string nm);
        logic [31:0] d;
        bit found;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            rd(2'd2, d);
            if (d == v) begin
                found = 1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: count never reached %0d (last %0d)", nm, v, d);
        end
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        int          mode;
        int          exp_c;
        logic        exp_irq;

        reset = 1'b1;
        Addr  = 32'd0;
        WE    = 1'b0;
        Din   = 32'd0;
        step();
        step();
        chk("reset_irq", {31'd0, IRQ}, 32'd0);
        rd(2'd0, d); chk("reset_ctrl", d, 32'd0);
        reset = 1'b0;

        // Register access with Enable held low
        vecs[0] = '{1'b0, 2'd0, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h0,        32'h0};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 2'd0, 32'hFFFFFFF6, 32'h6};
        vecs[6] = '{1'b1, 2'd2, 32'h12345678, 32'h0};
        vecs[7] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
        vecs[8] = '{1'b0, 2'd1, 32'h0,        32'hDEADBEEF};
        vecs[9] = '{1'b1, 2'd0, 32'h0,        32'h0};
        for (int i = 0; i < 10; i++) begin
            Addr = {28'd0, vecs[i].a, 2'b00};
            Din  = vecs[i].din;
            WE   = vecs[i].we;
            step();
            WE   = 1'b0;
            rd(vecs[i].a, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // One-shot, PRESET=3, IM set
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        step();
        for (int k = 2; k <= 5; k++) begin
            step();
            rd(2'd2, d); chk($sformatf("oneshot_count_e%0d", k), d, 32'd5 - k);
            chk($sformatf("oneshot_irq_e%0d", k), {31'd0, IRQ}, (k == 5) ? 32'd1 : 32'd0);
        end
        step(); step();
        rd(2'd0, d); chk("oneshot_ctrl_after", d, 32'h8);
        chk("oneshot_irq_sticky", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h8);
        chk("oneshot_irq_clear", {31'd0, IRQ}, 32'd0);

        // Auto-reload, PRESET=2: pulse every 5 edges starting at E4
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("reload_irq_e%0d", k), {31'd0, IRQ},
                (k >= 4 && (k - 4) % 5 == 0) ? 32'd1 : 32'd0);
        end
        wr(2'd0, 32'h0);
        step(); step();

        // Masked terminal count
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("mask_irq_e%0d", k), {31'd0, IRQ}, 32'd0);
        end
        chk("mask_flag_set", {31'd0, dut.irq_flag}, 32'd1);
        wr(2'd0, 32'h9);
        chk("mask_unmask_irq", {31'd0, IRQ}, 32'd0);
        chk("mask_flag_clear", {31'd0, dut.irq_flag}, 32'd0);
        step();
        chk("mask_irq_next", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h0);
        step(); step();

        // PRESET=0 behaves like PRESET=1
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(); step();
        rd(2'd2, d); chk("zero_count_e2", d, 32'd0);
        step();
        chk("zero_irq_e3", {31'd0, IRQ}, 32'd1);
        rd(2'd3, d); chk("zero_read_c", d, 32'd0);
        wr(2'd0, 32'h8);
        chk("zero_irq_clear", {31'd0, IRQ}, 32'd0);

        // Disable mid-count freezes COUNT; re-enable reloads
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        wait_count(32'd6, "dis_wait6");
        wr(2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd(2'd2, d); chk($sformatf("dis_frozen%0d", k), d, 32'd5);
            step();
        end
        wr(2'd2, 32'h55);
        rd(2'd2, d); chk("dis_count_wr_ignored", d, 32'd5);
        wr(2'd0, 32'h1);
        step();
        rd(2'd2, d); chk("reen_load_pending", d, 32'd5);
        step();
        rd(2'd2, d); chk("reen_reloaded", d, 32'd10);

        // CTRL write in the INT cycle keeps the written Enable
        wait_count(32'd1, "prio_wait1");
        step();
        wr(2'd0, 32'h1);
        rd(2'd0, d); chk("prio_ctrl", d, 32'h1);
        step(); step();
        rd(2'd2, d); chk("prio_restart", d, 32'd10);

        // Asynchronous reset mid-count
        wr(2'd0, 32'h9);
        wait_count(32'd4, "rst_wait4");
        #1 reset = 1'b1;
        #1;
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d); chk($sformatf("rst_read%0d", a), d, 32'd0);
        end
        reset = 1'b0;
        step(); step(); step();
        rd(2'd2, d); chk("rst_idle_count", d, 32'd0);

        // Randomized timing against the arithmetic timeline
        for (int t = 0; t < 6; t++) begin
            n    = $urandom_range(1, 8);
            mode = $urandom_range(0, 3);
            wr(2'd1, n);
            wr(2'd0, {28'd0, 1'b1, mode[1:0], 1'b1});
            for (int k = 1; k <= n + 4; k++) begin
                step();
                if (k >= 2) begin
                    exp_c = (n - (k - 2) > 0) ? n - (k - 2) : 0;
                    rd(2'd2, d); chk($sformatf("rnd%0d_count_e%0d", t, k), d, exp_c);
                end
                exp_irq = (mode == 1) ? (k == n + 2) : (k >= n + 2);
                chk($sformatf("rnd%0d_irq_e%0d", t, k), {31'd0, IRQ}, {31'd0, exp_irq});
            end
            rd(2'd0, d);
            chk($sformatf("rnd%0d_ctrl", t), d, {28'd0, 1'b1, mode[1:0], (mode == 1) ? 1'b1 : 1'b0});
            wr(2'd0, 32'h0);
            step(); step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
